// File: rtl/hbridge_ramp_ctrl_if.sv
// ---------------------------------------------------------------------------
// hbridge_ramp_ctrl_if
// Stream bundle feeding the H-bridge amplitude ramp controller.
//   s_axis_tdata_phase / s_axis_tvalid_phase   : DDS phase samples (no ready,
//                                                the controller only observes)
//   s_axis_tdata_target / s_axis_tvalid_target : requested amplitude
//   s_axis_tready_target                       : target accepted when
//                                                valid && ready on a rising edge
// The master modport is the stream source; the slave modport is the controller.
// ---------------------------------------------------------------------------
interface hbridge_ramp_ctrl_if #(
  parameter int AXIS_TDATA_PHASE_WIDTH = 16,
  parameter int CFG_DATA_WIDTH         = 16
);
  logic [AXIS_TDATA_PHASE_WIDTH-1:0] s_axis_tdata_phase;
  logic                              s_axis_tvalid_phase;
  logic [CFG_DATA_WIDTH-1:0]         s_axis_tdata_target;
  logic                              s_axis_tvalid_target;
  logic                              s_axis_tready_target;

  modport master (
    output s_axis_tdata_phase,
    output s_axis_tvalid_phase,
    output s_axis_tdata_target,
    output s_axis_tvalid_target,
    input  s_axis_tready_target
  );

  modport slave (
    input  s_axis_tdata_phase,
    input  s_axis_tvalid_phase,
    input  s_axis_tdata_target,
    input  s_axis_tvalid_target,
    output s_axis_tready_target
  );
endinterface

// File: rtl/hbridge_ramp_ctrl.sv
// ---------------------------------------------------------------------------
// hbridge_ramp_ctrl
// Ramps the amplitude word of an H-bridge generator toward a requested target,
// changing it only at phase-period boundaries (phase wrap) so the bridge never
// sees an amplitude step mid-period.
//
// Ports
//   clk, aresetn  : clock, synchronous active-low reset
//   s_axis        : phase stream and target stream (hbridge_ramp_ctrl_if.slave)
//   cfg_step      : amplitude change per phase period, 0 = jump to goal
//   cfg_enable    : 1 = run, 0 = ramp down to zero and idle
//   cfg_data_out  : registered amplitude for the generator
//   busy          : high while ramping (RAMP or STOP)
//   ramp_done     : one-cycle pulse when the output reaches the current goal
//   dbg_state     : current FSM state (IDLE=0, RAMP=1, HOLD=2, STOP=3)
//
// Handshake: a target transfers on a rising edge where s_axis_tvalid_target and
// s_axis_tready_target are both high; ready is combinational from cfg_enable
// and the state, and never depends on valid.
// ---------------------------------------------------------------------------
module hbridge_ramp_ctrl #(
  parameter int AXIS_TDATA_PHASE_WIDTH = 16,
  parameter int CFG_DATA_WIDTH         = 16,
  parameter int AMP_MAX                = 8192
) (
  input  logic                      clk,
  input  logic                      aresetn,
  hbridge_ramp_ctrl_if.slave        s_axis,
  input  logic [CFG_DATA_WIDTH-1:0] cfg_step,
  input  logic                      cfg_enable,
  output logic [CFG_DATA_WIDTH-1:0] cfg_data_out,
  output logic                      busy,
  output logic                      ramp_done,
  output logic [1:0]                dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_HOLD = 2'd2,
    ST_STOP = 2'd3
  } state_t;

  localparam logic [CFG_DATA_WIDTH-1:0] AMP_LIMIT = AMP_MAX[CFG_DATA_WIDTH-1:0];

  state_t                              state_q, state_d;
  logic [CFG_DATA_WIDTH-1:0]           out_q, out_d;
  logic [CFG_DATA_WIDTH-1:0]           goal_q, goal_d;
  logic                                done_q, done_d;
  logic [AXIS_TDATA_PHASE_WIDTH-1:0]   prev_q, prev_d;
  logic                                have_prev_q, have_prev_d;

  logic                                wrap;
  logic                                accept;
  logic                                tready;
  logic [CFG_DATA_WIDTH-1:0]           tgt_sat;
  logic [CFG_DATA_WIDTH-1:0]           stepped;
  logic [CFG_DATA_WIDTH:0]             out_x, goal_x, step_x, sum_x, gap_x;

  // A wrap is a valid sample below the previous valid sample; invalid cycles
  // neither flag nor update history, and an empty history never wraps.
  assign wrap = s_axis.s_axis_tvalid_phase && have_prev_q &&
                (s_axis.s_axis_tdata_phase < prev_q);

  assign tready = cfg_enable && ((state_q == ST_IDLE) || (state_q == ST_HOLD));
  assign accept = tready && s_axis.s_axis_tvalid_target;
  assign s_axis.s_axis_tready_target = tready;

  assign tgt_sat = (s_axis.s_axis_tdata_target > AMP_LIMIT) ? AMP_LIMIT
                                                            : s_axis.s_axis_tdata_target;

  // One step toward goal_q, computed one bit wider so out + step cannot wrap.
  // Clamps to the goal rather than overshooting; step 0 jumps straight there.
  always_comb begin
    out_x   = {1'b0, out_q};
    goal_x  = {1'b0, goal_q};
    step_x  = {1'b0, cfg_step};
    sum_x   = out_x + step_x;
    gap_x   = '0;
    stepped = goal_q;
    if (cfg_step == '0) begin
      stepped = goal_q;
    end else if (out_q < goal_q) begin
      stepped = (sum_x >= goal_x) ? goal_q : sum_x[CFG_DATA_WIDTH-1:0];
    end else begin
      gap_x   = out_x - goal_x;
      stepped = (gap_x <= step_x) ? goal_q : (out_q - cfg_step);
    end
  end

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    goal_d      = goal_q;
    done_d      = 1'b0;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;

    if (s_axis.s_axis_tvalid_phase) begin
      prev_d      = s_axis.s_axis_tdata_phase;
      have_prev_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          goal_d = tgt_sat;
          if (tgt_sat == '0) begin
            state_d = ST_HOLD;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RAMP;
          end
        end
      end
      ST_RAMP: begin
        // Disable wins over a coincident wrap: no step on the disabling cycle.
        if (!cfg_enable) begin
          state_d = ST_STOP;
          goal_d  = '0;
        end else if (wrap) begin
          out_d = stepped;
          if (stepped == goal_q) begin
            state_d = ST_HOLD;
            done_d  = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (!cfg_enable) begin
          state_d = ST_STOP;
          goal_d  = '0;
        end else if (accept) begin
          goal_d = tgt_sat;
          if (tgt_sat == out_q) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_RAMP;
          end
        end
      end
      ST_STOP: begin
        // Goal is zero here; an output already at zero finishes without a wrap.
        if (out_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (wrap) begin
          out_d = stepped;
          if (stepped == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      out_q       <= '0;
      goal_q      <= '0;
      done_q      <= 1'b0;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      goal_q      <= goal_d;
      done_q      <= done_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
    end
  end

  assign cfg_data_out = out_q;
  assign ramp_done    = done_q;
  assign busy         = (state_q == ST_RAMP) || (state_q == ST_STOP);
  assign dbg_state    = state_q;

endmodule
